mem_access_unit: RTL and testbench

Byte-addressed load/store front end for the 64-bit doubleword data memory in the 5-stage pipeline. Sits between the EX/MEM register and the data memory. Converts byte addresses into doubleword indices and handles sub-doubleword stores (sb/sh/sw) with a two-cycle read-modify-write, stalling the pipeline for one cycle. Also extracts, aligns and sign/zero-extends load data for the MEM/WB register, and flags misaligned or out-of-range accesses.

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline/memory signal bundle for mem_access_unit: request fields from EX/MEM,
// the doubleword memory port, and the load/stall/fault results.
interface mem_access_unit_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [63:0] ALUresult;
  logic [63:0] storeData;
  logic        flush;
  logic [63:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [63:0] loadData;
  logic        stall;
  logic        fault;

  modport master (
    output MemRead, MemWrite, funct3, ALUresult, storeData, flush, mem_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata, loadData, stall, fault
  );

  modport slave (
    input  MemRead, MemWrite, funct3, ALUresult, storeData, flush, mem_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata, loadData, stall, fault
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a doubleword data memory; sub-doubleword
// stores use a two-cycle read-modify-write. Optional macro MISALIGN_TRAP_EN traps misalignment.
module mem_access_unit #(
  parameter int DEPTH = 128
) (
  input logic             clk,
  input logic             reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  state_t      state_reg, state_next;
  logic [63:0] buffer_reg, buffer_next;

  logic [2:0]  off;
  logic [2:0]  aoff;
  logic [1:0]  size_code;
  logic        request, illegal, out_of_range, fault_raw, access_ok;
  logic        is_load, is_sd, is_sub;
  logic [7:0]  be_base, be;
  logic [63:0] wdata_shift, merged, shifted, load_ext;

  assign off          = bus.ALUresult[2:0];
  assign size_code    = bus.funct3[1:0];
  assign request      = bus.MemRead | bus.MemWrite;
  assign out_of_range = (bus.ALUresult >= LIMIT);
  assign illegal      = (bus.MemRead & bus.MemWrite)
                      | (bus.MemWrite & bus.funct3[2])
                      | (bus.MemRead & (bus.funct3 == 3'b111));
  assign is_load = bus.MemRead & ~bus.MemWrite;
  assign is_sd   = bus.MemWrite & ~bus.MemRead & (bus.funct3 == 3'b011);
  assign is_sub  = bus.MemWrite & ~bus.MemRead & ~bus.funct3[2] & (size_code != 2'b11);

  // Misalignment either traps or is absorbed by clearing the offending offset bits.
  always_comb begin
    aoff = off;
`ifdef MISALIGN_TRAP_EN
    fault_raw = request & (illegal | out_of_range
              | ((size_code == 2'b01) & off[0])
              | ((size_code == 2'b10) & (off[1:0] != 2'b00))
              | ((size_code == 2'b11) & (off != 3'b000)));
`else
    fault_raw = request & (illegal | out_of_range);
    case (size_code)
      2'b01:   aoff = {off[2:1], 1'b0};
      2'b10:   aoff = {off[2], 2'b00};
      2'b11:   aoff = 3'b000;
      default: aoff = off;
    endcase
`endif
  end

  assign access_ok = ~bus.flush & ~fault_raw;

  always_comb begin
    case (size_code)
      2'b00:   be_base = 8'h01;
      2'b01:   be_base = 8'h03;
      2'b10:   be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
  end

  assign be          = be_base << aoff;
  assign wdata_shift = bus.storeData << {aoff, 3'b000};
  assign shifted     = bus.mem_rdata >> {aoff, 3'b000};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = be[gi] ? wdata_shift[gi*8 +: 8] : bus.mem_rdata[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    case (bus.funct3)
      3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_ext = shifted;
      3'b100:  load_ext = {56'd0, shifted[7:0]};
      3'b101:  load_ext = {48'd0, shifted[15:0]};
      3'b110:  load_ext = {32'd0, shifted[31:0]};
      default: load_ext = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      buffer_reg <= 64'd0;
    end else begin
      state_reg  <= state_next;
      buffer_reg <= buffer_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    buffer_next = buffer_reg;
    case (state_reg)
      IDLE: begin
        if (access_ok && is_sub) begin
          state_next  = WRITE;
          buffer_next = merged;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = 64'd0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 64'd0;
    bus.loadData  = 64'd0;
    bus.stall     = 1'b0;
    bus.fault     = 1'b0;
    if (!reset) begin
      bus.mem_addr = {3'b000, bus.ALUresult[63:3]};
      if (state_reg == WRITE) begin
        // Commit the merged doubleword unless the pipeline cancelled the store.
        bus.mem_we    = ~bus.flush;
        bus.mem_wdata = buffer_reg;
      end else begin
        bus.fault = fault_raw;
        if (access_ok) begin
          if (is_load) begin
            bus.mem_re   = 1'b1;
            bus.loadData = load_ext;
          end
          if (is_sd) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.storeData;
          end
          if (is_sub) begin
            bus.mem_re = 1'b1;
            bus.stall  = 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random loads/stores
// checked against a byte-array memory model.
module tb_mem_access_unit;
  localparam int DEPTH = 16;
  localparam int NBYTES = DEPTH * 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] mem [DEPTH];
  logic [7:0]  ref_bytes [NBYTES];

  mem_access_unit_if bus ();

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = (bus.mem_addr < 64'(DEPTH)) ? mem[bus.mem_addr[3:0]] : 64'd0;

  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_addr < 64'(DEPTH))
      mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [63:0] addr);
    logic bad;
    int   sz;
    sz  = 1 << f3[1:0];
    bad = (rd && wr) || (wr && f3[2]) || (rd && f3 == 3'b111);
    if (addr >= 64'(NBYTES)) bad = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((addr % 64'(sz)) != 64'd0) bad = 1'b1;
`endif
    return (rd || wr) && bad;
  endfunction

  function automatic logic [63:0] model_load(input int a, input int sz, input logic [2:0] f3);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < sz; i++) v = v | (64'(ref_bytes[a + i]) << (8 * i));
    if (!f3[2] && sz < 8 && v[8 * sz - 1]) v = v | (~64'd0 << (8 * sz));
    return v;
  endfunction

  function automatic logic [63:0] model_dword(input int a);
    logic [63:0] v;
    int base;
    base = a - (a % 8);
    v = 64'd0;
    for (int i = 0; i < 8; i++) v = v | (64'(ref_bytes[base + i]) << (8 * i));
    return v;
  endfunction

  task automatic idle_inputs();
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.funct3    = 3'b000;
    bus.ALUresult = 64'd0;
    bus.storeData = 64'd0;
    bus.flush     = 1'b0;
  endtask

  // Called 1 time unit after a posedge; returns 1 time unit after the posedge ending the access.
  // abort: 0 none, 1 flush during WRITE, 2 reset during WRITE.
  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] data, input int abort);
    logic f, ld, sd, sub;
    int   sz, a;
    logic [63:0] exp_w;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.funct3    = f3;
    bus.ALUresult = addr;
    bus.storeData = data;
    bus.flush     = 1'b0;
    #3;
    sz  = 1 << f3[1:0];
    f   = exp_fault(rd, wr, f3, addr);
    a   = f ? 0 : int'(addr) - (int'(addr) % sz);
    ld  = rd && !wr && !f;
    sd  = wr && !rd && !f && f3 == 3'b011;
    sub = wr && !rd && !f && !sd;
    check("fault", 64'(f), 64'(bus.fault));
    check("mem_re", 64'(ld || sub), 64'(bus.mem_re));
    check("mem_we", 64'(sd), 64'(bus.mem_we));
    check("stall", 64'(sub), 64'(bus.stall));
    check("loadData", bus.loadData, ld ? model_load(a, sz, f3) : 64'd0);
    if (!f) check("mem_addr", bus.mem_addr, {3'b000, addr[63:3]});
    if (sd) check("sd_wdata", bus.mem_wdata, data);
    @(posedge clk); #1;
    if (sd) for (int i = 0; i < 8; i++) ref_bytes[a + i] = data[8 * i +: 8];
    if (sub) begin
      exp_w = model_dword(a);
      for (int i = 0; i < sz; i++) exp_w[8 * ((a % 8) + i) +: 8] = data[8 * i +: 8];
      if (abort == 1) bus.flush = 1'b1;
      if (abort == 2) reset = 1'b1;
      #3;
      check("wr_stall", 64'd0, 64'(bus.stall));
      check("wr_we", 64'(abort == 0), 64'(bus.mem_we));
      if (abort == 0) begin
        check("rmw_wdata", bus.mem_wdata, exp_w);
        check("rmw_addr", bus.mem_addr, {3'b000, addr[63:3]});
      end
      @(posedge clk); #1;
      if (abort == 0) for (int i = 0; i < sz; i++) ref_bytes[a + i] = data[8 * i +: 8];
      reset     = 1'b0;
      bus.flush = 1'b0;
    end
    $display("xact rd=%0b wr=%0b f3=%0d addr=%h data=%h abort=%0d fault=%0b",
             rd, wr, f3, addr, data, abort, f);
    idle_inputs();
  endtask

  initial begin
    logic [63:0] addr, data;
    logic [2:0]  f3;
    int kind;
    idle_inputs();
    @(posedge clk); #1;
    // Outputs must be silent while reset is held, whatever the request.
    bus.MemWrite  = 1'b1;
    bus.ALUresult = 64'h12;
    bus.storeData = 64'hFFFF;
    #3;
    check("rst_re", 64'd0, 64'(bus.mem_re));
    check("rst_we", 64'd0, 64'(bus.mem_we));
    check("rst_stall", 64'd0, 64'(bus.stall));
    check("rst_fault", 64'd0, 64'(bus.fault));
    check("rst_addr", 64'd0, bus.mem_addr);
    check("rst_wdata", 64'd0, bus.mem_wdata);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    #1;
    check("rst_load", 64'd0, bus.loadData);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    #3;
    check("idle_re", 64'd0, 64'(bus.mem_re));
    check("idle_load", 64'd0, bus.loadData);
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) begin
      data = (i == 2) ? 64'h8877665544332211 : {$urandom, $urandom};
      xact(1'b0, 1'b1, 3'b011, 64'(i * 8), data, 0);
    end

    xact(1'b1, 1'b0, 3'b000, 64'h13, 64'd0, 0);
    check("lb13_const", model_load(8'h13, 1, 3'b000), 64'h44);
    xact(1'b1, 1'b0, 3'b000, 64'h17, 64'd0, 0);
    check("lb17_const", model_load(8'h17, 1, 3'b000), 64'hFFFFFFFFFFFFFF88);
    xact(1'b1, 1'b0, 3'b101, 64'h16, 64'd0, 0);
    xact(1'b0, 1'b1, 3'b001, 64'h12, 64'hABCD, 0);
    check("sh_merge", model_dword(8'h10), 64'h88776655ABCD2211);
    xact(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 0);
    xact(1'b0, 1'b1, 3'b011, 64'h08, 64'h0123456789ABCDEF, 0);
    xact(1'b0, 1'b1, 3'b000, 64'h19, 64'h5A, 2);
    xact(1'b1, 1'b0, 3'b011, 64'h18, 64'd0, 0);
    xact(1'b0, 1'b1, 3'b000, 64'h1A, 64'hA5, 1);
    xact(1'b1, 1'b0, 3'b011, 64'h18, 64'd0, 0);
    xact(1'b1, 1'b0, 3'b010, 64'h0A, 64'd0, 0);
    xact(1'b1, 1'b0, 3'b011, 64'(NBYTES), 64'd0, 0);
    xact(1'b1, 1'b1, 3'b011, 64'h20, 64'd0, 0);
    xact(1'b0, 1'b1, 3'b110, 64'h20, 64'd1, 0);
    xact(1'b0, 1'b1, 3'b010, 64'h24, 64'hDEADBEEF, 0);
    xact(1'b0, 1'b1, 3'b000, 64'h27, 64'h77, 0);
    xact(1'b1, 1'b0, 3'b011, 64'h20, 64'd0, 0);

    // Flush in IDLE cancels a sub-doubleword store before it starts.
    bus.MemWrite  = 1'b1;
    bus.funct3    = 3'b000;
    bus.ALUresult = 64'h30;
    bus.storeData = 64'hEE;
    bus.flush     = 1'b1;
    #3;
    check("flush_re", 64'd0, 64'(bus.mem_re));
    check("flush_stall", 64'd0, 64'(bus.stall));
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.MemWrite = 1'b0;
    #3;
    check("flush_no_write", 64'd0, 64'(bus.mem_we));
    $display("xact flush_idle sb addr=30");
    @(posedge clk); #1;
    idle_inputs();
    xact(1'b1, 1'b0, 3'b011, 64'h30, 64'd0, 0);

    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 9);
      addr = 64'($urandom_range(0, NBYTES - 1));
      data = {$urandom, $urandom};
      if (kind < 5) begin
        f3 = 3'($urandom_range(0, 6));
        xact(1'b1, 1'b0, f3, addr, 64'd0, 0);
      end else if (kind < 9) begin
        f3 = 3'($urandom_range(0, 3));
        xact(1'b0, 1'b1, f3, addr, data, 0);
      end else begin
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) xact(1'b1, 1'b1, f3, addr, data, 0);
        else xact(1'b1, 1'b0, 3'b011, addr + 64'(NBYTES), 64'd0, 0);
      end
    end

    for (int i = 0; i < DEPTH; i++) xact(1'b1, 1'b0, 3'b011, 64'(i * 8), 64'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
